// File: rtl/bioz_demod_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bioz_demod_pkg
//  Purpose  : Shared types and default widths for the BioZ I/Q demodulator
//             and windowed accumulator.
//  Contents : state_e       - demodulator FSM state encoding
//             DEF_DATA_W    - default ADC sample width
//             DEF_ACC_W     - default accumulator / result width
//             DEF_CNT_W     - default sample-counter width
//  Revision : 1.0  initial release
// ============================================================================
package bioz_demod_pkg;

  localparam int DEF_DATA_W = 12;
  localparam int DEF_ACC_W  = 24;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_ACCUM = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/bioz_sat_accum.sv
`default_nettype none
// ============================================================================
//  Module   : bioz_sat_accum
//  Purpose  : Signed saturating accumulator. Adds or subtracts a signed
//             sample each enabled cycle and clamps at the signed range limits.
//  Ports    : clk_i   - clock
//             rst_i   - asynchronous active-high reset
//             clr_i   - synchronous clear (wins over enable)
//             en_i    - accumulate this cycle
//             sub_i   - 1: acc -= data_i, 0: acc += data_i
//             data_i  - signed sample, DATA_W bits
//             acc_o   - signed accumulator, ACC_W bits
//             sat_o   - high in a cycle whose update clamped
//  Revision : 1.0  initial release
// ============================================================================
module bioz_sat_accum #(
  parameter int DATA_W = 12,
  parameter int ACC_W  = 24
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic                     sub_i,
  input  logic signed [DATA_W-1:0] data_i,
  output logic signed [ACC_W-1:0]  acc_o,
  output logic                     sat_o
);

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [DATA_W:0]   ext, term;
  logic [ACC_W:0]    sum;
  logic              ovf;

  // One guard bit before negation keeps -(-2^(DATA_W-1)) exact.
  assign ext  = {data_i[DATA_W-1], data_i};
  assign term = sub_i ? (~ext + 1'b1) : ext;
  assign sum  = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-DATA_W){term[DATA_W]}}, term};
  // Guard bit disagreeing with the result MSB means the true sum left the range.
  assign ovf  = sum[ACC_W] ^ sum[ACC_W-1];

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      if (ovf) acc_d = sum[ACC_W] ? ACC_MIN : ACC_MAX;
      else     acc_d = sum[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign acc_o = acc_q;
  assign sat_o = en_i & ~clr_i & ovf;

endmodule
`default_nettype wire

// File: rtl/bioz_iq_demod_accum.sv
`default_nettype none
// ============================================================================
//  Module   : bioz_iq_demod_accum
//  Purpose  : Synchronous I/Q demodulator for the BioZ chain. Accumulates
//             +/-sample against the registered IP/QP references over a
//             programmable number of excitation periods and presents the
//             sums through a valid/ready handshake.
//  Ports    : clk_i, rst_i       - clock, asynchronous active-high reset
//             start_i, abort_i   - arm a window / cancel everything
//             num_periods_i      - periods per window (0 acts as 1)
//             ip_i, qp_i         - reference clocks from the generator
//             sample_valid_i, sample_i - ADC sample stream
//             i_out_o, q_out_o   - signed I/Q sums
//             sample_cnt_o       - samples accumulated (saturating)
//             overflow_o         - an accumulator clamped in this window
//             out_valid_o, out_ready_i - result handshake
//             busy_o             - measurement in progress or result pending
//  Revision : 1.0  initial release
// ============================================================================
module bioz_iq_demod_accum
  import bioz_demod_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic [7:0]               num_periods_i,
  input  logic                     ip_i,
  input  logic                     qp_i,
  input  logic                     sample_valid_i,
  input  logic signed [DATA_W-1:0] sample_i,
  output logic signed [ACC_W-1:0]  i_out_o,
  output logic signed [ACC_W-1:0]  q_out_o,
  output logic [CNT_W-1:0]         sample_cnt_o,
  output logic                     overflow_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic                     busy_o
);

  state_e             state_q, state_d;
  logic               ip_r_q, qp_r_q, ip_d_q;
  logic [7:0]         num_per_q, num_per_d;
  logic [7:0]         per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0]   samp_cnt_q, samp_cnt_d;
  logic               ovf_q, ovf_d;

  logic               period_edge, start_ok, terminal, acc_en, acc_clr;
  logic               sat_i, sat_q;

  assign period_edge = ip_r_q & ~ip_d_q;
  assign start_ok    = (state_q == ST_IDLE) & start_i & ~abort_i;
  // The edge that closes the window is not part of it.
  assign terminal    = (state_q == ST_ACCUM) & period_edge &
                       ((per_cnt_q + 8'd1) == num_per_q);
  // The edge that leaves ARM is the first cycle of the window.
  assign acc_en      = ~abort_i & sample_valid_i &
                       (((state_q == ST_ARM) & period_edge) |
                        ((state_q == ST_ACCUM) & ~terminal));
  assign acc_clr     = abort_i | start_ok;

  bioz_sat_accum #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_acc_i (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (acc_clr),
    .en_i   (acc_en),
    .sub_i  (~ip_r_q),
    .data_i (sample_i),
    .acc_o  (i_out_o),
    .sat_o  (sat_i)
  );

  bioz_sat_accum #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_acc_q (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (acc_clr),
    .en_i   (acc_en),
    .sub_i  (~qp_r_q),
    .data_i (sample_i),
    .acc_o  (q_out_o),
    .sat_o  (sat_q)
  );

  always_comb begin
    state_d    = state_q;
    num_per_d  = num_per_q;
    per_cnt_d  = per_cnt_q;
    samp_cnt_d = samp_cnt_q;
    ovf_d      = ovf_q;

    if (acc_clr) begin
      per_cnt_d  = '0;
      samp_cnt_d = '0;
      ovf_d      = 1'b0;
    end else begin
      if ((state_q == ST_ACCUM) && period_edge) per_cnt_d = per_cnt_q + 8'd1;
      if (acc_en && (samp_cnt_q != {CNT_W{1'b1}})) samp_cnt_d = samp_cnt_q + 1'b1;
      if (sat_i | sat_q) ovf_d = 1'b1;
    end

    // Window length is captured once so mid-window changes are harmless.
    if (start_ok) num_per_d = (num_periods_i == 8'd0) ? 8'd1 : num_periods_i;

    if (abort_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:  if (start_i)     state_d = ST_ARM;
        ST_ARM:   if (period_edge) state_d = ST_ACCUM;
        ST_ACCUM: if (terminal)    state_d = ST_DONE;
        ST_DONE:  if (out_ready_i) state_d = ST_IDLE;
        default:                   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      ip_r_q     <= 1'b0;
      qp_r_q     <= 1'b0;
      ip_d_q     <= 1'b0;
      num_per_q  <= 8'd1;
      per_cnt_q  <= '0;
      samp_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ip_r_q     <= ip_i;
      qp_r_q     <= qp_i;
      ip_d_q     <= ip_r_q;
      num_per_q  <= num_per_d;
      per_cnt_q  <= per_cnt_d;
      samp_cnt_q <= samp_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign sample_cnt_o = samp_cnt_q;
  assign overflow_o   = ovf_q;
  assign out_valid_o  = (state_q == ST_DONE);
  assign busy_o       = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bioz_iq_demod_accum.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bioz_iq_demod_accum
//  Purpose  : Directed self-checking bench for bioz_iq_demod_accum with a
//             32-cycle IP reference and QP lagging by 8 cycles.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bioz_iq_demod_accum;

  localparam int DATA_W = 12;
  localparam int ACC_W  = 16;
  localparam int CNT_W  = 16;

  logic                     clk_i = 1'b0;
  logic                     rst_i;
  logic                     start_i, abort_i;
  logic [7:0]               num_periods_i;
  logic                     ip_i, qp_i, sample_valid_i;
  logic signed [DATA_W-1:0] sample_i;
  logic signed [ACC_W-1:0]  i_out_o, q_out_o;
  logic [CNT_W-1:0]         sample_cnt_o;
  logic                     overflow_o, out_valid_o, out_ready_i, busy_o;

  int   errors = 0;
  int   checks = 0;
  int   ph = 0;
  int   amp = 100;
  int   mode = 0;      // 0: constant +amp, 1: +amp when IP_r high else -amp
  int   sv_mode = 0;   // 0: always valid, 1: valid every other cycle
  logic m_ipr = 1'b0, m_ipd = 1'b0, prev_edge = 1'b0;

  always #5 clk_i = ~clk_i;

  bioz_iq_demod_accum #(.DATA_W(DATA_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .abort_i        (abort_i),
    .num_periods_i  (num_periods_i),
    .ip_i           (ip_i),
    .qp_i           (qp_i),
    .sample_valid_i (sample_valid_i),
    .sample_i       (sample_i),
    .i_out_o        (i_out_o),
    .q_out_o        (q_out_o),
    .sample_cnt_o   (sample_cnt_o),
    .overflow_o     (overflow_o),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .busy_o         (busy_o)
  );

  task automatic chk(input string tag, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic drive();
    ip_i = ((ph % 32) < 16);
    qp_i = (((ph + 24) % 32) < 16);
    sample_valid_i = (sv_mode == 1) ? ph[0] : 1'b1;
    if (mode == 1) sample_i = DATA_W'(m_ipr ? amp : -amp);
    else           sample_i = DATA_W'(amp);
  endtask

  // Advance one clock; the model tracks the DUT's IP_r / IP_d registers.
  task automatic step();
    @(posedge clk_i);
    prev_edge = m_ipr & ~m_ipd;
    if (rst_i) begin
      m_ipr = 1'b0;
      m_ipd = 1'b0;
    end else begin
      m_ipd = m_ipr;
      m_ipr = ip_i;
    end
    #1;
    ph++;
    drive();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " iout"},  longint'(i_out_o), 0);
    chk({tag, " qout"},  longint'(q_out_o), 0);
    chk({tag, " cnt"},   longint'(sample_cnt_o), 0);
    chk({tag, " ovf"},   longint'(overflow_o), 0);
    chk({tag, " valid"}, longint'(out_valid_o), 0);
    chk({tag, " busy"},  longint'(busy_o), 0);
  endtask

  task automatic run_window(input string tag, input logic [7:0] np, input int exp_edges,
                            input longint exp_i, input longint exp_q,
                            input longint exp_cnt, input longint exp_ovf);
    int edges;
    int budget;
    num_periods_i = np;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk({tag, " busy"}, longint'(busy_o), 1);
    num_periods_i = ~np;   // must not affect the running window
    edges = 0;
    budget = 0;
    while (!out_valid_o && budget < 10000) begin
      step();
      if (prev_edge) edges++;
      budget++;
    end
    chk({tag, " valid"}, longint'(out_valid_o), 1);
    chk({tag, " edges"}, longint'(edges), longint'(exp_edges));
    chk({tag, " termlat"}, longint'(prev_edge), 1);
    chk({tag, " iout"}, longint'(i_out_o), exp_i);
    chk({tag, " qout"}, longint'(q_out_o), exp_q);
    chk({tag, " cnt"},  longint'(sample_cnt_o), exp_cnt);
    chk({tag, " ovf"},  longint'(overflow_o), exp_ovf);
  endtask

  task automatic handshake(input string tag);
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    chk({tag, " hs valid"}, longint'(out_valid_o), 0);
    chk({tag, " hs busy"},  longint'(busy_o), 0);
  endtask

  initial begin
    rst_i = 1'b1;
    start_i = 1'b0;
    abort_i = 1'b0;
    out_ready_i = 1'b0;
    num_periods_i = 8'd1;
    drive();
    repeat (3) step();
    check_zero("reset");
    rst_i = 1'b0;
    repeat (5) step();

    // Constant sample: in-phase and quadrature sums cancel.
    mode = 0; amp = 100;
    run_window("w1", 8'd1, 2, 0, 0, 32, 0);
    handshake("w1");

    // Sample sign follows IP_r: I = 128*100, Q cancels.
    mode = 1; amp = 100;
    run_window("w2", 8'd4, 5, 12800, 0, 128, 0);
    for (int i = 0; i < 10; i++) begin
      start_i = (i == 3);
      step();
    end
    start_i = 1'b0;
    chk("hold valid", longint'(out_valid_o), 1);
    chk("hold busy",  longint'(busy_o), 1);
    chk("hold iout",  longint'(i_out_o), 12800);
    chk("hold cnt",   longint'(sample_cnt_o), 128);
    handshake("w2");

    // Full-scale in-phase drive over 255 periods clamps I.
    mode = 1; amp = 2047;
    run_window("sat", 8'd255, 256, 32767, 0, 8160, 1);
    handshake("sat");

    // Half the cycles valid; terminal edge sample excluded.
    mode = 0; amp = 100; sv_mode = 1;
    run_window("sv", 8'd2, 3, 0, 0, 32, 0);
    handshake("sv");
    sv_mode = 0;

    // Reset in the middle of a window.
    mode = 1; amp = 100;
    num_periods_i = 8'd4;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    repeat (50) step();
    rst_i = 1'b1;
    m_ipr = 1'b0;
    m_ipd = 1'b0;
    #1;
    check_zero("rstmid");
    step();
    rst_i = 1'b0;

    // Abort in the middle of a window.
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    repeat (50) step();
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    check_zero("abort");

    // Abort wins over a simultaneous Start.
    abort_i = 1'b1;
    start_i = 1'b1;
    step();
    abort_i = 1'b0;
    start_i = 1'b0;
    chk("abort+start busy", longint'(busy_o), 0);

    // NumPeriods = 0 behaves as one period.
    mode = 0;
    run_window("np0", 8'd0, 2, 0, 0, 32, 0);
    handshake("np0");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bioz_iq_demod_accum.md
# bioz_iq_demod_accum

Synchronous I/Q demodulator and windowed accumulator for the BioZ signal chain. It sits directly downstream of the DAC-control signal generator. It consumes the generator's in-phase (IP) and quadrature (QP) reference clocks together with the ADC sample stream of the measured body voltage. Over a programmable number of excitation periods it accumulates ±sample for each reference and presents the I/Q sums through a valid/ready handshake.

## Interface
- DATA_W, 12, ADC sample width (signed two's complement)
- ACC_W, 24, accumulator/output width (signed), ACC_W > DATA_W+1
- CNT_W, 16, width of accumulated-sample counter
- Clk  in  1  system clock; shares the generator's clock domain
- Reset  in  1  asynchronous, active-high reset
- Start  in  1  one-cycle pulse; arms a measurement when idle
- Abort  in  1  return to IDLE and clear accumulators
- NumPeriods  in  8  excitation periods per window; 0 treated as 1
- IP  in  1  in-phase reference from signal generator
- QP  in  1  quadrature reference from signal generator
- SampleValid  in  1  Sample qualifier
- Sample  in  DATA_W  signed ADC sample
- IOut  out  ACC_W  signed I accumulation result
- QOut  out  ACC_W  signed Q accumulation result
- SampleCnt  out  CNT_W  number of samples accumulated in window (saturates at all-ones)
- Overflow  out  1  set if either accumulator saturated during window
- OutValid  out  1  result available
- OutReady  in  1  consumer accepts result
- Busy  out  1  high in ARM, ACCUM, DONE

## Operation
- IP and QP are registered once (IP_r, QP_r). IP_d is IP_r delayed one cycle. A period edge is IP_r & ~IP_d.
- FSM has four states: IDLE, ARM, ACCUM, DONE.
- IDLE: Start -> ARM. On this transition the accumulators, SampleCnt, the period counter and Overflow clear.
- ARM: on a period edge -> ACCUM. The edge cycle counts as the first cycle of the window, and its sample is accumulated.
- ACCUM: each SampleValid cycle performs IAcc += IP_r ? Sample : -Sample and QAcc += QP_r ? Sample : -Sample. Sample is sign-extended to DATA_W+1 bits before negation, so -2^(DATA_W-1) is exact. SampleCnt increments on each SampleValid cycle.
- ACCUM: each period edge increments the period counter. When the counter reaches NumPeriods (1 for 0), the FSM goes to DONE. A sample in that terminal edge cycle is NOT accumulated.
- DONE: OutValid=1. IOut, QOut, SampleCnt and Overflow are held stable. On OutValid & OutReady -> IDLE.
- Saturation: each accumulator clamps at +(2^(ACC_W-1)-1) / -2^(ACC_W-1). Any clamp sets Overflow, which stays sticky until the next Start.
- Start is ignored outside IDLE.
- Abort from any state -> IDLE next cycle, with accumulators, SampleCnt and Overflow cleared and OutValid low. Abort has priority over Start, edges and handshake.
- NumPeriods is sampled on the Start cycle. Later changes do not affect the running window.

## Timing
- Reset values: IOut=0, QOut=0, SampleCnt=0, Overflow=0, OutValid=0, Busy=0. FSM=IDLE; IP_r, QP_r, IP_d = 0.
- Reset asserted mid-window aborts immediately. No partial result is ever presented.
- Reference latency is 1 cycle: Sample at cycle t is multiplied by IP/QP as seen at cycle t-1.
- Start at cycle t -> Busy=1 at t+1.
- Terminal edge at cycle t -> OutValid=1 at t+1.
- Handshake completes at cycle t -> OutValid=0 and Busy=0 at t+1. A new Start is accepted from t+1.
- OutReady while OutValid=0 has no effect.

## Structure
- Package bioz_demod_pkg holds the FSM state enum (IDLE/ARM/ACCUM/DONE) and the default widths DATA_W, ACC_W, CNT_W.
- Sub-module bioz_sat_accum: signed saturating accumulator with clear, enable and add/subtract select. It is instantiated twice (I and Q) and outputs its sat flag.
- The top level holds the reference registers, edge detect, period counter, SampleCnt, FSM and handshake.

## Test plan
- IP period 32 cycles (16 high/16 low), QP = IP shifted 8 cycles, NumPeriods=1, Sample=+100 every cycle -> IOut=0, QOut=0, SampleCnt=32, Overflow=0.
- Same references, Sample=+100 when IP_r=1 and -100 otherwise, NumPeriods=4 -> IOut=12800, QOut=0, SampleCnt=128.
- ACC_W=16, Sample=+2047 in phase with IP_r, NumPeriods=255 -> IOut=32767, Overflow=1, OutValid asserted one cycle after the 256th edge counted from ARM.
- Hold OutReady low 10 cycles in DONE -> OutValid stays 1 and outputs stay constant. Pulse OutReady -> OutValid=0 next cycle. A Start issued during DONE is ignored.
- Assert Reset mid-ACCUM, and separately pulse Abort mid-ACCUM -> all outputs 0 and FSM in IDLE. A new Start then completes a window of NumPeriods=0, which yields exactly one period (SampleCnt=32).
- SampleValid toggling every other cycle, NumPeriods=2, period 32 -> SampleCnt=32. The sample in the terminal edge cycle is excluded.
